avalon_arbiter: RTL and testbench

Two-master, one-slave arbiter for the Avalon-MM programming port of the user-logic memory block. It lets two independent hosts share the single `s0`-style slave port: for example, the runtime's program loader and a debug/readback path. It serialises their transactions with round-robin fairness and honours the slave's `waitrequest` stalls. It also flags stalls that exceed a configurable bound.

---
 rtl/avalon_arbiter.sv | 152 +++++++++++++++
 tb/tb_avalon_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter with round-robin fairness.
// Lets two hosts, such as the program loader and a debug/readback path,
// share one slave programming port. One transfer is in flight at a time.
// Slave waitrequest stalls are passed to the owning master, and a sticky
// flag is set when one transfer stalls for MAX_WAIT cycles.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; downstream strobes low; both masters stalled
// OWNED | master `grant` is routed to the downstream port
module avalon_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 1024
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_waitrequest,

  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_waitrequest,

  output logic [ADDR_WIDTH-1:0] d_address,
  output logic                  d_read,
  output logic                  d_write,
  output logic [DATA_WIDTH-1:0] d_writedata,
  input  logic [DATA_WIDTH-1:0] d_readdata,
  input  logic                  d_waitrequest,

  output logic                  grant,
  output logic                  busy,
  output logic                  timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
  // The count that becomes WAIT_MAX on the next stalled cycle.
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t          state;
  logic            grant_q;
  logic            last_q;
  logic [CW-1:0]   stall_cnt;
  logic            timeout_q;

  logic            req0;
  logic            req1;
  logic            owner_rd;
  logic            owner_wr;
  logic            owner_req;
  logic            grant_nxt;
  logic            owned;

  // Request decode and round-robin grant choice for the next IDLE cycle.
  always_comb begin
    req0      = m0_read | m0_write;
    req1      = m1_read | m1_write;
    owner_rd  = grant_q ? m1_read  : m0_read;
    owner_wr  = grant_q ? m1_write : m0_write;
    owner_req = owner_rd | owner_wr;
    owned     = (state == OWNED);
    // On a tie the master that did not finish last wins; otherwise the
    // sole requester wins (req1 alone selects master 1).
    if (req0 && req1) begin
      grant_nxt = ~last_q;
    end else begin
      grant_nxt = req1;
    end
  end

  // Ownership FSM: arbitrate in IDLE, release on completion or abandon.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant_q <= grant_nxt;
            state   <= OWNED;
          end
        end
        OWNED: begin
          if (!owner_req) begin
            // The owner withdrew mid-transfer. No transfer completed, so the
            // fairness pointer is left alone.
            state <= IDLE;
          end else if (!d_waitrequest) begin
            last_q <= grant_q;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall counter and sticky timeout; the transfer itself is never aborted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else if (state == IDLE) begin
      stall_cnt <= '0;
    end else if (d_waitrequest) begin
      if (stall_cnt != WAIT_MAX) begin
        stall_cnt <= stall_cnt + CW'(1);
      end
      if (stall_cnt == WAIT_LAST) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Downstream mux and per-master stall routing, combinational from state.
  always_comb begin
    d_address   = grant_q ? m1_address   : m0_address;
    d_writedata = grant_q ? m1_writedata : m0_writedata;
    // A simultaneous read and write is treated as a write.
    d_write     = owned & owner_wr;
    d_read      = owned & owner_rd & ~owner_wr;

    m0_waitrequest = (owned && !grant_q) ? d_waitrequest : 1'b1;
    m1_waitrequest = (owned &&  grant_q) ? d_waitrequest : 1'b1;

    // Read data is broadcast; only the owner's completion cycle matters.
    m0_readdata = d_readdata;
    m1_readdata = d_readdata;

    grant   = grant_q;
    busy    = owned;
    timeout = timeout_q;
  end

endmodule

// File: tb/tb_avalon_arbiter.sv
// Self-checking bench for avalon_arbiter: per-cycle vector table checked
// through a scoreboard queue, plus a hand-driven stalled write.
module tb_avalon_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  localparam int NO = 0;
  localparam int RD = 2;
  localparam int WR = 1;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] m0_address = '0;
  logic          m0_read = 1'b0;
  logic          m0_write = 1'b0;
  logic [DW-1:0] m0_writedata = '0;
  logic [DW-1:0] m0_readdata;
  logic          m0_waitrequest;
  logic [AW-1:0] m1_address = '0;
  logic          m1_read = 1'b0;
  logic          m1_write = 1'b0;
  logic [DW-1:0] m1_writedata = '0;
  logic [DW-1:0] m1_readdata;
  logic          m1_waitrequest;
  logic [AW-1:0] d_address;
  logic          d_read;
  logic          d_write;
  logic [DW-1:0] d_writedata;
  logic [DW-1:0] d_readdata = '0;
  logic          d_waitrequest = 1'b0;
  logic          grant;
  logic          busy;
  logic          timeout;

  avalon_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
    .grant(grant), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int rst;
    int m0; int a0; int wd0;
    int m1; int a1; int wd1;
    int dwr; int drd;
    int e_dr; int e_dw; int e_a; int e_wd;
    int e_w0; int e_w1; int e_busy; int e_grant; int e_to;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t v(int rst, int m0, int a0, int wd0, int m1, int a1, int wd1,
                             int dwr, int drd, int e_dr, int e_dw, int e_a, int e_wd,
                             int e_w0, int e_w1, int e_busy, int e_grant, int e_to);
    vec_t r;
    r.id = 0; r.rst = rst;
    r.m0 = m0; r.a0 = a0; r.wd0 = wd0;
    r.m1 = m1; r.a1 = a1; r.wd1 = wd1;
    r.dwr = dwr; r.drd = drd;
    r.e_dr = e_dr; r.e_dw = e_dw; r.e_a = e_a; r.e_wd = e_wd;
    r.e_w0 = e_w0; r.e_w1 = e_w1; r.e_busy = e_busy; r.e_grant = e_grant; r.e_to = e_to;
    return r;
  endfunction

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, id, act, exp);
    end
  endtask

  // Scoreboard consumer: compare each driven cycle's expectations mid-cycle.
  always @(negedge clk) begin
    vec_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("d_read", e.id, 32'(d_read), e.e_dr);
      check("d_write", e.id, 32'(d_write), e.e_dw);
      check("m0_waitrequest", e.id, 32'(m0_waitrequest), e.e_w0);
      check("m1_waitrequest", e.id, 32'(m1_waitrequest), e.e_w1);
      check("busy", e.id, 32'(busy), e.e_busy);
      check("timeout", e.id, 32'(timeout), e.e_to);
      if (e.e_busy != 0) check("grant", e.id, 32'(grant), e.e_grant);
      if (e.e_dr != 0 || e.e_dw != 0) begin
        check("d_address", e.id, d_address, e.e_a);
        check("m0_readdata", e.id, m0_readdata, e.drd);
        check("m1_readdata", e.id, m1_readdata, e.drd);
      end
      if (e.e_dw != 0) check("d_writedata", e.id, d_writedata, e.e_wd);
    end
  end

  task automatic apply(input vec_t x);
    @(posedge clk);
    #1;
    reset         = (x.rst != 0);
    m0_read       = x.m0[1];
    m0_write      = x.m0[0];
    m0_address    = x.a0;
    m0_writedata  = x.wd0;
    m1_read       = x.m1[1];
    m1_write      = x.m1[0];
    m1_address    = x.a1;
    m1_writedata  = x.wd1;
    d_waitrequest = (x.dwr != 0);
    d_readdata    = x.drd;
    sb.push_back(x);
  endtask

  initial begin
    vec_t idle_v;
    vec_t rst_v;
    int   stall;
    int   strobes;
    int   done;
    logic [31:0] wd;

    idle_v = v(0, NO, 0, 0, NO, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    rst_v  = v(1, NO, 0, 0, NO, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);

    // Reset state, then single write with no stall.
    tbl.push_back(rst_v);
    tbl.push_back(v(0, WR, 5, 32'hDEADBEEF, NO, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(0, WR, 5, 32'hDEADBEEF, NO, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 1, 1, 0, 0));
    tbl.push_back(idle_v);
    // Tie fairness after reset: 1, 2, 1, 2 with IDLE gaps.
    tbl.push_back(rst_v);
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(v(0, RD, 1, 0, RD, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      tbl.push_back(v(0, RD, 1, 0, RD, 2, 0, 0, 32'h11, 1, 0, 1, 0, 0, 1, 1, 0, 0));
      tbl.push_back(v(0, RD, 1, 0, RD, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      tbl.push_back(v(0, RD, 1, 0, RD, 2, 0, 0, 32'h22, 1, 0, 2, 0, 1, 0, 1, 1, 0));
    end
    tbl.push_back(idle_v);
    // m1 read stalled for three cycles.
    tbl.push_back(v(0, NO, 0, 0, RD, 7, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(v(0, NO, 0, 0, RD, 7, 0, 1, 0, 1, 0, 7, 0, 1, 1, 1, 1, 0));
    tbl.push_back(v(0, NO, 0, 0, RD, 7, 0, 0, 32'h0000000E, 1, 0, 7, 0, 1, 0, 1, 1, 0));
    tbl.push_back(idle_v);
    // Timeout with MAX_WAIT=4: ten stall cycles, flag from the fifth on.
    tbl.push_back(v(0, RD, 3, 0, NO, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    for (int k = 0; k < 10; k++)
      tbl.push_back(v(0, RD, 3, 0, NO, 0, 0, 1, 0, 1, 0, 3, 0, 1, 1, 1, 0, (k >= 4) ? 1 : 0));
    tbl.push_back(v(0, RD, 3, 0, NO, 0, 0, 0, 32'h55, 1, 0, 3, 0, 0, 1, 1, 0, 1));
    tbl.push_back(v(0, NO, 0, 0, NO, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(v(1, NO, 0, 0, NO, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(idle_v);
    // Reset while m1 is stalled; the following tie goes to m0 first.
    tbl.push_back(v(0, NO, 0, 0, RD, 9, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0, RD, 9, 0, 1, 0, 1, 0, 9, 0, 1, 1, 1, 1, 0));
    tbl.push_back(v(1, NO, 0, 0, RD, 9, 0, 1, 0, 1, 0, 9, 0, 1, 1, 1, 1, 0));
    tbl.push_back(v(0, RD, 1, 0, RD, 9, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(0, RD, 1, 0, RD, 9, 0, 0, 32'h33, 1, 0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(0, RD, 1, 0, RD, 9, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(0, RD, 1, 0, RD, 9, 0, 0, 32'h44, 1, 0, 9, 0, 1, 0, 1, 1, 0));
    tbl.push_back(idle_v);
    // Read+write collision: only the write goes downstream.
    tbl.push_back(v(0, RW, 4, 32'h1234, NO, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(0, RW, 4, 32'h1234, NO, 0, 0, 0, 0, 0, 1, 4, 32'h1234, 0, 1, 1, 0, 0));
    tbl.push_back(idle_v);
    // m1 abandons mid-stall; last stays at m0, so the next tie goes to m1.
    tbl.push_back(v(0, NO, 0, 0, RD, 6, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(0, NO, 0, 0, RD, 6, 0, 1, 0, 1, 0, 6, 0, 1, 1, 1, 1, 0));
    tbl.push_back(v(0, NO, 0, 0, NO, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0));
    tbl.push_back(idle_v);
    tbl.push_back(v(0, RD, 1, 0, RD, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(0, RD, 1, 0, RD, 2, 0, 0, 32'h66, 1, 0, 2, 0, 1, 0, 1, 1, 0));
    tbl.push_back(idle_v);

    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t x;
      x = tbl[i];
      x.id = i;
      apply(x);
    end

    // Hand-driven m1 write with a random stall length.
    stall = $urandom_range(0, 3);
    wd = $urandom;
    @(posedge clk);
    #1;
    m0_read = 1'b0; m0_write = 1'b0;
    m1_read = 1'b0; m1_write = 1'b1;
    m1_address = 32'h10; m1_writedata = wd;
    d_waitrequest = (stall > 0);
    strobes = 0;
    done = 0;
    for (int c = 0; c < 20 && done == 0; c++) begin
      @(negedge clk);
      if (d_write) begin
        strobes++;
        if (!m1_waitrequest) begin
          done = 1;
          check("hs_address", -1, d_address, 32'h10);
          check("hs_writedata", -1, d_writedata, wd);
        end
      end
      if (done == 0) begin
        @(posedge clk);
        #1;
        d_waitrequest = (strobes < stall);
      end
    end
    check("hs_completed", -1, 32'(done), 32'd1);
    check("hs_strobe_cycles", -1, 32'(strobes), 32'(stall + 1));
    check("hs_timeout", -1, 32'(timeout), 32'd0);
    @(posedge clk);
    #1;
    m1_write = 1'b0;
    d_waitrequest = 1'b0;
    @(negedge clk);
    check("hs_busy_after", -1, 32'(busy), 32'd0);
    check("sb_drain", -1, 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
